// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, digit width and the digit-count helper used by the
// binary-to-BCD serialiser.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    localparam int BCD_W = 4;

    function automatic int ndig_for(input int bin_w);
        longint v;
        int n;
        v = (longint'(1) << bin_w) - 1;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 to any digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] a,
    output logic [3:0] y
);
    assign y = (a >= 4'd5) ? a + 4'd3 : a;
endmodule

// File: rtl/bin_to_bcd_serial.sv
// bin_to_bcd_serial: sequential double-dabble conversion, then streams BCD digits
// most-significant first over a valid/ready handshake.
module bin_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int BIN_W       = 10,
    parameter int NDIG        = 4,
    parameter bit SUPPRESS_LZ = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [BIN_W-1:0]                     in_bin,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [3:0]                           out_digit,
    output logic [(NDIG > 1 ? $clog2(NDIG) : 1)-1:0] out_index,
    output logic                                 out_last
);
    localparam int BCD_BITS = NDIG * BCD_W;
    localparam int SR_W     = BCD_BITS + BIN_W;
    localparam int IDX_W    = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int CNT_W    = $clog2(BIN_W + 1);

    if (NDIG < ndig_for(BIN_W)) begin : g_ndig_check
        $error("bin_to_bcd_serial: NDIG too small for BIN_W");
    end

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_BITS-1:0] fixed;
    logic [SR_W-1:0]    nxt;
    logic [BCD_BITS-1:0] res;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   prev_idx;

    for (genvar i = 0; i < NDIG; i++) begin : g_add3
        bcd_add3 u_add3 (
            .a(sr[BIN_W + i*BCD_W +: BCD_W]),
            .y(fixed[i*BCD_W +: BCD_W])
        );
    end

    assign nxt = {fixed, sr[BIN_W-1:0]} << 1;
    // res is the finished BCD value on the last CONV edge
    assign res = nxt[SR_W-1:BIN_W];
    assign prev_idx = out_index - 1'b1;
    assign in_ready = (state == IDLE);
    assign out_last = out_valid && (out_index == '0);

    always_comb begin
        start_idx = SUPPRESS_LZ ? '0 : IDX_W'(NDIG - 1);
        for (int i = 0; i < NDIG; i++)
            if (SUPPRESS_LZ && res[i*BCD_W +: BCD_W] != '0) start_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_digit <= '0;
            out_index <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr    <= {{BCD_BITS{1'b0}}, in_bin};
                    cnt   <= '0;
                    state <= CONV;
                end
                CONV: begin
                    sr  <= nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_index <= start_idx;
                        out_digit <= res[start_idx*BCD_W +: BCD_W];
                    end
                end
                EMIT: if (out_ready) begin
                    if (out_index == '0) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        out_index <= prev_idx;
                        out_digit <= sr[BIN_W + prev_idx*BCD_W +: BCD_W];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// tb_bin_to_bcd_serial: checks two instances (leading zeros kept / suppressed)
// against a decimal arithmetic model.
module tb_bin_to_bcd_serial;

    localparam int BIN_W = 10;
    localparam int NDIG  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       in_valid = '0;
    logic [1:0]       in_ready;
    logic [1:0][9:0]  in_bin = '0;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready = '0;
    logic [1:0][3:0]  out_digit;
    logic [1:0][1:0]  out_index;
    logic [1:0]       out_last;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_serial #(.BIN_W(BIN_W), .NDIG(NDIG), .SUPPRESS_LZ(1'b0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bin(in_bin[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_digit(out_digit[0]), .out_index(out_index[0]), .out_last(out_last[0])
    );

    bin_to_bcd_serial #(.BIN_W(BIN_W), .NDIG(NDIG), .SUPPRESS_LZ(1'b1)) dut_lz (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bin(in_bin[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_digit(out_digit[1]), .out_index(out_index[1]), .out_last(out_last[1])
    );

    function automatic int dig(input int v, input int i);
        return (v / (10 ** i)) % 10;
    endfunction

    function automatic logic ready_pat(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return c < 1 ? 1'b1 : c < 6 ? 1'b0 : c[0];
        return 1'($urandom_range(0, 1));
    endfunction

    // Sends one word on instance s and checks latency, digit stream and handshake.
    task automatic run_word(input int s, input int v, input int mode,
                            input bit hold, input int hold_data, input bit chain);
        int st, n, lat, c, g, e;
        st = NDIG - 1;
        if (s == 1) begin
            st = 0;
            for (int i = 0; i < NDIG; i++) if (dig(v, i) != 0) st = i;
        end
        n = st + 1;
        @(negedge clk);
        n_cmp++;
        if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0) begin
            n_bad++;
            $display("FAIL idle[%0d] v=%0d: in_ready=%b out_valid=%b, need 1/0", s, v, in_ready[s], out_valid[s]);
        end
        in_valid[s] = 1'b1;
        in_bin[s] = 10'(v);
        @(posedge clk);
        #1;
        if (hold) in_bin[s] = 10'(hold_data);
        else in_valid[s] = 1'b0;
        lat = 0;
        while (out_valid[s] !== 1'b1 && lat < 4 * BIN_W) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_cmp++;
        if (lat != BIN_W) begin
            n_bad++;
            $display("FAIL latency[%0d] v=%0d: got %0d edges, need %0d", s, v, lat, BIN_W);
        end
        c = 0;
        for (int k = 0; k < n; k++) begin
            g = 0;
            e = dig(v, st - k);
            do begin
                @(negedge clk);
                out_ready[s] = ready_pat(mode, c);
                c++;
                g++;
                n_cmp++;
                if (out_valid[s] !== 1'b1 || out_digit[s] !== 4'(e) || out_index[s] !== 2'(st - k)
                    || out_last[s] !== (k == n - 1) || in_ready[s] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL digit[%0d] v=%0d k=%0d: valid=%b digit=%0d idx=%0d last=%b in_ready=%b, need 1/%0d/%0d/%0b/0",
                             s, v, k, out_valid[s], out_digit[s], out_index[s], out_last[s], in_ready[s],
                             e, st - k, k == n - 1);
                end
                @(posedge clk);
            end while (!out_ready[s] && g < 64);
        end
        #1;
        if (!chain) in_valid[s] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({in_ready[s], out_valid[s], out_digit[s], out_index[s], out_last[s]} !== 9'b1_0_0000_00_0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b, need 100000000", s,
                         {in_ready[s], out_valid[s], out_digit[s], out_index[s], out_last[s]});
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        run_word(0, 255, 0, 1'b0, 0, 1'b0);
        run_word(0, 1023, 0, 1'b0, 0, 1'b0);
        run_word(0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_suppress();
        run_word(1, 7, 0, 1'b0, 0, 1'b0);
        run_word(1, 0, 0, 1'b0, 0, 1'b0);
        run_word(1, 100, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_word(0, 409, 1, 1'b1, 999, 1'b0);
        run_word(0, 56, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_bin[0] = 10'd300;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready[0], out_valid[0], out_digit[0], out_index[0], out_last[0]} !== 9'b1_0_0000_00_0) begin
            n_bad++;
            $display("FAIL reset_conv: got %b, need 100000000",
                     {in_ready[0], out_valid[0], out_digit[0], out_index[0], out_last[0]});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_bin[0] = 10'd409;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (BIN_W + 1) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_index[0] !== 2'd2 || out_digit[0] !== 4'd4) begin
            n_bad++;
            $display("FAIL pre_reset_emit: valid=%b idx=%0d digit=%0d, need 1/2/4", out_valid[0], out_index[0], out_digit[0]);
        end
        out_ready[0] = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready[0], out_valid[0], out_digit[0], out_index[0], out_last[0]} !== 9'b1_0_0000_00_0) begin
            n_bad++;
            $display("FAIL reset_emit: got %b, need 100000000",
                     {in_ready[0], out_valid[0], out_digit[0], out_index[0], out_last[0]});
        end
        @(negedge clk);
        reset = 1'b1;
        run_word(0, 42, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_word(0, 12, 0, 1'b1, 34, 1'b1);
        run_word(0, 34, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        int v;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 20; i++) begin
                v = i == 0 ? 1023 : i == 1 ? 0 : i < 6 ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 1023));
                run_word(s, v, 2, 1'b0, 0, 1'b0);
            end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_suppress();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
